// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic WIDTH x DEPTH register pipeline
// with valid/ready handshake, bubble collapse and sync flush.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   FLUSH      synchronous clear of all stage valids
//   IN         input data word
//   IN_VALID   IN holds a valid word
//   IN_READY   pipeline accepts IN this cycle
//   OUT        data of the last stage
//   OUT_VALID  last stage holds a valid word
//   OUT_READY  consumer accepts OUT this cycle
//   OCC        number of valid stages (registered)
//   STALL_CNT  saturating stall counter, present only
//              when PIPE_REG_CHAIN_STALL_CNT_EN is defined
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [OCC_W-1:0] OCC
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  ,
  output logic [15:0]      STALL_CNT
`endif
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] d_nxt [DEPTH];

  // rdy[i]: stage i may load this edge
  logic [DEPTH-1:0] rdy;
  logic             rdy_acc;

  // cv/cd: valid and data offered to stage i
  logic [DEPTH-1:0] cv;
  logic [WIDTH-1:0] cd [DEPTH];

  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_src
      if (g == 0) begin : g_head
        assign cv[g] = IN_VALID;
        assign cd[g] = IN;
      end else begin : g_body
        assign cv[g] = v[g-1];
        assign cd[g] = d[g-1];
      end
    end
  endgenerate

  // Ready ripples back from the consumer; any empty
  // stage at or after i lets stage i advance, which
  // is what collapses bubbles.
  always_comb begin
    rdy     = '0;
    rdy_acc = OUT_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_acc = !v[i] || rdy_acc;
      rdy[i]  = rdy_acc;
    end
  end

  // Data is only captured behind a valid word so a
  // drained pipeline keeps its last OUT value.
  always_comb begin
    v_nxt = v;
    d_nxt = d;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_nxt[i] = cv[i];
        if (cv[i]) begin
          d_nxt[i] = cd[i];
        end
      end
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v   <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else if (FLUSH) begin
      v   <= '0;
      occ <= '0;
    end else begin
      v   <= v_nxt;
      occ <= occ_nxt;
      d   <= d_nxt;
    end
  end

  assign IN_READY  = rdy[0];
  assign OUT       = d[DEPTH-1];
  assign OUT_VALID = v[DEPTH-1];
  assign OCC       = occ;

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      stall_cnt <= '0;
    end else if (v[DEPTH-1] && !OUT_READY &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign STALL_CNT = stall_cnt;
`else
  // no stall counter in this build
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed self-checking bench
// for pipe_reg_chain at WIDTH=8, DEPTH=3.
module tb_pipe_reg_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST;
  logic             FLUSH;
  logic [WIDTH-1:0] IN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] OUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [OCC_W-1:0] OCC;
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
  logic [15:0]      STALL_CNT;
`endif

  int checks = 0;
  int errors = 0;

  pipe_reg_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .FLUSH    (FLUSH),
    .IN       (IN),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OUT      (OUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OCC      (OCC)
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    ,
    .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [7:0] w);
    IN       = w;
    IN_VALID = 1'b1;
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    FLUSH     = 1'b0;
    IN        = '0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("rst_out",   OUT, 0);
    chk("rst_ovld",  OUT_VALID, 0);
    chk("rst_occ",   OCC, 0);
    chk("rst_irdy",  IN_READY, 1);
`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    chk("rst_stall", STALL_CNT, 0);
`endif

    // streaming at full rate
    OUT_READY = 1'b1;
    offer(8'h11);
    chk("s1_occ",  OCC, 1);
    chk("s1_ovld", OUT_VALID, 0);
    offer(8'h22);
    chk("s2_occ",  OCC, 2);
    offer(8'h33);
    chk("s3_occ",  OCC, 3);
    chk("s3_ovld", OUT_VALID, 1);
    chk("s3_out",  OUT, 8'h11);
    IN_VALID = 1'b0;
    tick();
    chk("s4_out",  OUT, 8'h22);
    chk("s4_occ",  OCC, 2);
    tick();
    chk("s5_out",  OUT, 8'h33);
    chk("s5_occ",  OCC, 1);
    tick();
    chk("s6_ovld", OUT_VALID, 0);
    chk("s6_occ",  OCC, 0);
    chk("s6_hold", OUT, 8'h33);

    // backpressure fill then drain
    OUT_READY = 1'b0;
    offer(8'hA1);
    chk("b1_occ", OCC, 1);
    offer(8'hA2);
    chk("b2_occ", OCC, 2);
    offer(8'hA3);
    chk("b3_occ", OCC, 3);
    IN = 8'hA4;
    #1;
    chk("b_full_irdy", IN_READY, 0);
    tick();
    chk("b_hold_occ", OCC, 3);
    chk("b_hold_out", OUT, 8'hA1);
    chk("b_hold_ovld", OUT_VALID, 1);
    OUT_READY = 1'b1;
    #1;
    chk("b_pass_irdy", IN_READY, 1);
    tick();
    IN_VALID = 1'b0;
    chk("d1_out", OUT, 8'hA2);
    chk("d1_occ", OCC, 3);
    tick();
    chk("d2_out", OUT, 8'hA3);
    chk("d2_occ", OCC, 2);
    tick();
    chk("d3_out", OUT, 8'hA4);
    chk("d3_occ", OCC, 1);
    tick();
    chk("d4_ovld", OUT_VALID, 0);
    chk("d4_occ", OCC, 0);

    // flush discards the word offered with it
    OUT_READY = 1'b0;
    offer(8'h01);
    offer(8'h02);
    chk("f_fill_occ", OCC, 2);
    IN    = 8'hFF;
    FLUSH = 1'b1;
    tick();
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    chk("f_occ",  OCC, 0);
    chk("f_ovld", OUT_VALID, 0);
    chk("f_out",  OUT, 8'hA4);
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("f_noff_ovld", OUT_VALID, 0);
      chk("f_noff_out", OUT, 8'hA4);
    end

    // reset mid-stream beats a simultaneous flush
    OUT_READY = 1'b0;
    offer(8'hB1);
    offer(8'hB2);
    offer(8'hB3);
    chk("r_fill_occ", OCC, 3);
    IN    = 8'hB4;
    RST   = 1'b1;
    FLUSH = 1'b1;
    tick();
    RST      = 1'b0;
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    #1;
    chk("r_occ",  OCC, 0);
    chk("r_ovld", OUT_VALID, 0);
    chk("r_out",  OUT, 8'h00);
    chk("r_irdy", IN_READY, 1);

`ifdef PIPE_REG_CHAIN_STALL_CNT_EN
    offer(8'hC1);
    IN_VALID = 1'b0;
    tick();
    tick();
    chk("st_ovld", OUT_VALID, 1);
    chk("st_zero", STALL_CNT, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("st_five", STALL_CNT, 5);
    chk("st_out",  OUT, 8'hC1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("st_flush", STALL_CNT, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
